// File: rtl/data_sync_pkg.sv
// Shared constants and the event-detect helper for the multi-channel data synchroniser.
package data_sync_pkg;

  localparam int MODE_LEVEL     = 0;
  localparam int MODE_TOGGLE    = 1;
  localparam int MIN_NUM_STAGES = 2;

  // Level sources fire on the synchronised rising edge; toggle sources fire on any change.
  function automatic logic detect_event(input int mode, input logic last, input logic prev);
    if (mode == MODE_TOGGLE) return last ^ prev;
    return last & ~prev;
  endfunction

endpackage

// File: rtl/data_sync_ch.sv
// One synchroniser channel: enable sync chain, edge detect, data capture, valid/overrun tracking.
// Overrun logic is present only when DATA_SYNC_MC_OVERRUN_EN is defined.
module data_sync_ch
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int WIDTH      = 8,
  parameter int MODE       = MODE_LEVEL
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] i_async_data,
  input  logic             i_en,
  input  logic             i_ready,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_pulse,
  output logic             o_overrun
);

  logic [NUM_STAGES-1:0] r_sync;
  logic                  r_edge;
  logic [WIDTH-1:0]      r_data;
  logic                  r_valid;
  logic                  r_pulse;
  logic                  w_event;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[NUM_STAGES-2:0], i_en};
      r_edge <= r_sync[NUM_STAGES-1];
    end
  end

  assign w_event = detect_event(MODE, r_sync[NUM_STAGES-1], r_edge);

  // Async data is assumed stable by the time its enable has crossed the chain.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_event;
      if (w_event) begin
        r_data  <= i_async_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef DATA_SYNC_MC_OVERRUN_EN
  logic r_ovr;

  // Set wins over clear so a coincident overwrite is never lost.
  always_ff @(posedge CLK) begin
    if (Reset)                              r_ovr <= 1'b0;
    else if (w_event && r_valid && !i_ready) r_ovr <= 1'b1;
    else if (i_ovr_clr)                     r_ovr <= 1'b0;
  end

  assign o_overrun = r_ovr;
`else
  logic w_unused_ovr_clr;
  assign w_unused_ovr_clr = i_ovr_clr;
  assign o_overrun        = 1'b0;
`endif

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified data synchroniser; one data_sync_ch per channel.
// Optional sticky overrun flags: define DATA_SYNC_MC_OVERRUN_EN.
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 2,
  parameter int MODE       = MODE_LEVEL
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] Async_bus,
  input  logic [CHANNELS-1:0]       bus_EN,
  input  logic [CHANNELS-1:0]       sync_ready,
  input  logic [CHANNELS-1:0]       overrun_clr,
  output logic [CHANNELS*WIDTH-1:0] sync_bus,
  output logic [CHANNELS-1:0]       sync_valid,
  output logic [CHANNELS-1:0]       EN_pulse,
  output logic [CHANNELS-1:0]       overrun
);

  if (NUM_STAGES < MIN_NUM_STAGES) begin : g_bad_stages
    $error("data_sync_mc: NUM_STAGES below minimum");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    data_sync_ch #(
      .NUM_STAGES (NUM_STAGES),
      .WIDTH      (WIDTH),
      .MODE       (MODE)
    ) u_ch (
      .CLK          (CLK),
      .Reset        (Reset),
      .i_async_data (Async_bus[c*WIDTH +: WIDTH]),
      .i_en         (bus_EN[c]),
      .i_ready      (sync_ready[c]),
      .i_ovr_clr    (overrun_clr[c]),
      .o_data       (sync_bus[c*WIDTH +: WIDTH]),
      .o_valid      (sync_valid[c]),
      .o_pulse      (EN_pulse[c]),
      .o_overrun    (overrun[c])
    );
  end

endmodule

// File: tb/tb_data_sync_mc.sv
// Directed bench: per-cycle vector table on a level-mode instance, plus hand sequences for toggle mode,
// reset mid-flight and simultaneous channel capture.
module tb_data_sync_mc;

`ifdef DATA_SYNC_MC_OVERRUN_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] Async_bus;
  logic [1:0]  bus_EN, sync_ready, overrun_clr;
  logic [15:0] bus0, bus1;
  logic [1:0]  valid0, valid1, pulse0, pulse1, ovr0, ovr1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  data_sync_mc #(.NUM_STAGES(2), .WIDTH(8), .CHANNELS(2), .MODE(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .Async_bus(Async_bus), .bus_EN(bus_EN),
    .sync_ready(sync_ready), .overrun_clr(overrun_clr),
    .sync_bus(bus0), .sync_valid(valid0), .EN_pulse(pulse0), .overrun(ovr0));

  data_sync_mc #(.NUM_STAGES(2), .WIDTH(8), .CHANNELS(2), .MODE(1)) dut1 (
    .CLK(CLK), .Reset(Reset), .Async_bus(Async_bus), .bus_EN(bus_EN),
    .sync_ready(sync_ready), .overrun_clr(overrun_clr),
    .sync_bus(bus1), .sync_valid(valid1), .EN_pulse(pulse1), .overrun(ovr1));

  typedef struct {
    logic       en;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic       pulse;
    logic       valid;
    logic [7:0] bus;
    logic       ovr;
  } vec_t;

  vec_t vt[32];

  function automatic vec_t mk(logic en, logic [7:0] data, logic rdy, logic clr,
                              logic pulse, logic valid, logic [7:0] bus, logic ovr);
    vec_t v;
    v.en = en; v.data = data; v.rdy = rdy; v.clr = clr;
    v.pulse = pulse; v.valid = valid; v.bus = bus; v.ovr = ovr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // en data rdy clr | pulse valid bus ovr  (level mode, 2 stages)
    vt[0]  = mk(1, 8'hA5, 0, 0, 0, 0, 8'h00, 0);
    vt[1]  = mk(0, 8'hA5, 0, 0, 0, 0, 8'h00, 0);
    vt[2]  = mk(0, 8'hA5, 0, 0, 1, 1, 8'hA5, 0);
    vt[3]  = mk(0, 8'h5A, 0, 0, 0, 1, 8'hA5, 0);
    vt[4]  = mk(0, 8'h5A, 1, 0, 0, 0, 8'hA5, 0);
    vt[5]  = mk(0, 8'h5A, 1, 0, 0, 0, 8'hA5, 0);
    vt[6]  = mk(1, 8'h11, 0, 0, 0, 0, 8'hA5, 0);
    vt[7]  = mk(0, 8'h11, 0, 0, 0, 0, 8'hA5, 0);
    vt[8]  = mk(0, 8'h11, 0, 0, 1, 1, 8'h11, 0);
    vt[9]  = mk(1, 8'h22, 0, 0, 0, 1, 8'h11, 0);
    vt[10] = mk(0, 8'h22, 0, 0, 0, 1, 8'h11, 0);
    vt[11] = mk(0, 8'h22, 0, 0, 1, 1, 8'h22, OV);
    vt[12] = mk(0, 8'h22, 0, 1, 0, 1, 8'h22, 0);
    vt[13] = mk(1, 8'h33, 0, 0, 0, 1, 8'h22, 0);
    vt[14] = mk(0, 8'h33, 0, 0, 0, 1, 8'h22, 0);
    vt[15] = mk(0, 8'h33, 1, 0, 1, 1, 8'h33, 0);
    vt[16] = mk(0, 8'h33, 1, 0, 0, 0, 8'h33, 0);
    vt[17] = mk(0, 8'h33, 0, 0, 0, 0, 8'h33, 0);
    vt[18] = mk(1, 8'h44, 0, 0, 0, 0, 8'h33, 0);
    vt[19] = mk(0, 8'h44, 0, 0, 0, 0, 8'h33, 0);
    vt[20] = mk(0, 8'h44, 0, 0, 1, 1, 8'h44, 0);
    vt[21] = mk(1, 8'h55, 0, 0, 0, 1, 8'h44, 0);
    vt[22] = mk(0, 8'h55, 0, 0, 0, 1, 8'h44, 0);
    vt[23] = mk(0, 8'h55, 0, 1, 1, 1, 8'h55, OV);
    vt[24] = mk(0, 8'h55, 0, 1, 0, 1, 8'h55, 0);
    vt[25] = mk(0, 8'h55, 1, 0, 0, 0, 8'h55, 0);
    vt[26] = mk(1, 8'h66, 0, 0, 0, 0, 8'h55, 0);
    vt[27] = mk(1, 8'h66, 0, 0, 0, 0, 8'h55, 0);
    vt[28] = mk(1, 8'h66, 0, 0, 1, 1, 8'h66, 0);
    vt[29] = mk(1, 8'h77, 0, 0, 0, 1, 8'h66, 0);
    vt[30] = mk(0, 8'h77, 0, 0, 0, 1, 8'h66, 0);
    vt[31] = mk(0, 8'h77, 0, 0, 0, 1, 8'h66, 0);

    Reset = 1'b1; Async_bus = '0; bus_EN = '0; sync_ready = '0; overrun_clr = '0;
    tick; tick;
    chk("rst_bus0",   bus0,   0);
    chk("rst_valid0", valid0, 0);
    chk("rst_pulse0", pulse0, 0);
    chk("rst_ovr0",   ovr0,   0);
    chk("rst_bus1",   bus1,   0);
    chk("rst_flags1", {valid1, pulse1, ovr1}, 0);
    Reset = 1'b0;
    tick;

    for (int i = 0; i < 32; i++) begin
      bus_EN[0]      = vt[i].en;
      Async_bus[7:0] = vt[i].data;
      sync_ready[0]  = vt[i].rdy;
      overrun_clr[0] = vt[i].clr;
      tick;
      chk($sformatf("v%0d_pulse", i), pulse0[0],  vt[i].pulse);
      chk($sformatf("v%0d_valid", i), valid0[0],  vt[i].valid);
      chk($sformatf("v%0d_bus", i),   bus0[7:0],  vt[i].bus);
      chk($sformatf("v%0d_ovr", i),   ovr0[0],    vt[i].ovr);
      chk($sformatf("v%0d_ch1", i),   {bus0[15:8], valid0[1], pulse0[1], ovr0[1]}, 0);
    end
    sync_ready = '0; overrun_clr = '0;
    tick; tick; tick; tick;

    // Toggle mode on channel 1: both edges of bus_EN produce a capture.
    bus_EN[1] = 1'b1; Async_bus[15:8] = 8'h11;
    tick; tick;
    chk("tog_rise_early", pulse1[1], 0);
    tick;
    chk("tog_rise_pulse", pulse1[1], 1);
    chk("tog_rise_bus",   bus1[15:8], 8'h11);
    chk("tog_rise_valid", valid1[1], 1);
    tick;
    chk("tog_rise_once",  pulse1[1], 0);
    bus_EN[1] = 1'b0; Async_bus[15:8] = 8'h22;
    tick; tick;
    chk("tog_fall_early", pulse1[1], 0);
    tick;
    chk("tog_fall_pulse", pulse1[1], 1);
    chk("tog_fall_bus",   bus1[15:8], 8'h22);
    chk("tog_fall_ovr",   ovr1[1], OV);
    tick;
    chk("tog_fall_once",  pulse1[1], 0);

    // Reset one cycle after bus_EN rise discards the in-flight event.
    bus_EN[0] = 1'b1; Async_bus[7:0] = 8'hA5;
    tick;
    Reset = 1'b1;
    tick;
    chk("mid_rst_bus0",   bus0, 0);
    chk("mid_rst_flags0", {valid0, pulse0, ovr0}, 0);
    chk("mid_rst_bus1",   bus1, 0);
    chk("mid_rst_flags1", {valid1, pulse1, ovr1}, 0);
    tick;
    Reset = 1'b0;
    tick;
    chk("rel1_pulse0", pulse0[0], 0);
    chk("rel1_pulse1", pulse1[0], 0);
    tick;
    chk("rel2_pulse0", pulse0[0], 0);
    chk("rel2_pulse1", pulse1[0], 0);
    tick;
    chk("rel3_pulse0", pulse0[0], 1);
    chk("rel3_bus0",   bus0[7:0], 8'hA5);
    chk("rel3_pulse1", pulse1[0], 1);
    chk("rel3_bus1",   bus1[7:0], 8'hA5);
    tick;
    chk("rel4_pulse0", pulse0[0], 0);
    chk("rel4_pulse1", pulse1[0], 0);

    // Simultaneous captures on both channels of the level-mode instance.
    bus_EN = 2'b00;
    tick; tick; tick; tick;
    bus_EN = 2'b11; Async_bus = 16'hC33C;
    tick; tick;
    chk("sim_early", pulse0, 2'b00);
    tick;
    chk("sim_pulse", pulse0, 2'b11);
    chk("sim_bus",   bus0,   16'hC33C);
    chk("sim_valid", valid0, 2'b11);
    tick;
    chk("sim_once",  pulse0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sync_mc.md
DATA_SYNC_MC -- requirements
Module: data_sync_mc

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2, synchroniser depth per channel (legal >= 2).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-003 SHALL have parameter CHANNELS, default 2, number of independent channels (legal >= 1).
REQ-004 SHALL have parameter MODE, default 0, event detection: 0 = rising edge of enable (level/pulse source), 1 = any edge (toggle source).
REQ-005 SHALL have port CLK  input  1  destination clock; all logic on rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port Async_bus  input  CHANNELS*WIDTH  source data; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-008 SHALL have port bus_EN  input  CHANNELS  asynchronous per-channel enable/toggle.
REQ-009 SHALL have port sync_ready  input  CHANNELS  consumer accepts held word.
REQ-010 SHALL have port overrun_clr  input  CHANNELS  clears sticky overrun flag.
REQ-011 SHALL have port sync_bus  output  CHANNELS*WIDTH  registered captured data, same packing as Async_bus.
REQ-012 SHALL have port sync_valid  output  CHANNELS  held word not yet accepted.
REQ-013 SHALL have port EN_pulse  output  CHANNELS  one-cycle pulse per capture.
REQ-014 SHALL have port overrun  output  CHANNELS  sticky: capture overwrote an unaccepted word.

Function
REQ-015 Each channel SHALL pass bus_EN[c] through a NUM_STAGES flop chain, then one edge-detect flop.
REQ-016 Event SHALL be: MODE 0 -> last stage 1 and edge flop 0; MODE 1 -> last stage != edge flop.
REQ-017 On event, sync_bus slice c SHALL load Async_bus slice c and EN_pulse[c] SHALL be 1 for exactly the next cycle; otherwise the slice holds.
REQ-018 Latency SHALL be: bus_EN change sampled at edge k -> EN_pulse and new sync_bus visible after edge k+NUM_STAGES.
REQ-019 sync_valid[c] SHALL set on event; clear when sync_valid[c] && sync_ready[c] with no event that cycle.
REQ-020 Event with sync_valid[c]=1 and sync_ready[c]=0: newest data SHALL overwrite, sync_valid stays 1, overrun[c] sets.
REQ-021 Event with sync_valid[c]=1 and sync_ready[c]=1: new data captured, sync_valid stays 1, no overrun.
REQ-022 overrun[c] SHALL hold until overrun_clr[c]; simultaneous set and clear SHALL leave it set.
REQ-023 Channels SHALL be fully independent; no cross-channel interaction.
REQ-024 sync_ready while sync_valid=0 SHALL have no effect.

Reset
REQ-025 Reset=1 at a CLK edge SHALL clear all sync chains, edge flops, sync_bus, sync_valid, EN_pulse and overrun to 0.
REQ-026 Reset mid-operation SHALL discard in-flight events; a bus_EN held high through reset SHALL produce one event NUM_STAGES+1 edges after Reset deasserts (both modes).

Configuration
REQ-027 Macro DATA_SYNC_MC_OVERRUN_EN defined: overrun logic per REQ-020/022 compiled in.
REQ-028 Macro undefined: overrun SHALL be constant 0, overrun_clr ignored, data overwrite behaviour unchanged.

Structure
REQ-029 Package data_sync_pkg SHALL hold MODE constants (MODE_LEVEL=0, MODE_TOGGLE=1) and minimum NUM_STAGES constant.
REQ-030 Per-channel logic SHALL be a sub-module data_sync_ch, instantiated CHANNELS times via generate.

Verification
REQ-031 NUM_STAGES=2, MODE 0: bus_EN[0] high 1 cycle with Async_bus[7:0]=0xA5 -> EN_pulse[0] one cycle, 3 edges later; sync_bus[7:0]=0xA5; sync_valid[0]=1.
REQ-032 MODE 1: bus_EN[1] toggles 0->1 then 1->0 with data 0x11 then 0x22 -> two EN_pulse[1], sync_bus[15:8] 0x11 then 0x22.
REQ-033 Two events, sync_ready=0 -> sync_bus holds second word, overrun=1; overrun_clr pulse -> overrun=0; without macro overrun stays 0.
REQ-034 Event coincident with sync_ready=1 on valid word -> new data, sync_valid stays 1, overrun 0; next ready -> sync_valid=0.
REQ-035 Reset asserted one cycle after bus_EN rise -> all outputs 0; bus_EN still high -> one event 3 edges after release.
REQ-036 Simultaneous events on channels 0 and 1 with 0x3C/0xC3 -> both captured same cycle, no interference.
